// File: rtl/maxpool_2x2_stream.sv
// maxpool_2x2_stream: streaming 2x2 stride-2 max pooling over a square raster map using a half-row line buffer
module maxpool_2x2_stream #(
  parameter int IN_SIZE    = 4,
  parameter int DATA_WIDTH = 48
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_en,
  input  logic signed [DATA_WIDTH-1:0] i_data,
  output logic                         o_en,
  output logic signed [DATA_WIDTH-1:0] o_data,
  output logic                         o_frame_done
);
  localparam int OUT_SIZE = IN_SIZE / 2;
  localparam int CW = $clog2(IN_SIZE);
  localparam int LW = OUT_SIZE > 1 ? $clog2(OUT_SIZE) : 1;
  localparam logic [CW-1:0] LAST = CW'(IN_SIZE - 1);
  localparam logic [CW-1:0] LAST_WIN = CW'(2 * OUT_SIZE - 1);
  localparam bit ODD = IN_SIZE % 2 == 1;
  logic [CW-1:0] col, row;
  logic signed [DATA_WIDTH-1:0] hold;
  logic signed [DATA_WIDTH-1:0] linebuf [OUT_SIZE];
  logic signed [DATA_WIDTH-1:0] pair_max, quad_max;
  logic [LW-1:0] lb_idx;
  logic active;
  always_comb begin
    active = !(ODD && (col == LAST || row == LAST));
    lb_idx = LW'(col >> 1);
    pair_max = hold > i_data ? hold : i_data;
    quad_max = pair_max > linebuf[lb_idx] ? pair_max : linebuf[lb_idx];
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      col <= '0;
      row <= '0;
      hold <= '0;
      o_en <= 1'b0;
      o_data <= '0;
      o_frame_done <= 1'b0;
    end else begin
      o_en <= i_en && active && row[0] && col[0];
      o_frame_done <= i_en && row == LAST_WIN && col == LAST_WIN;
      if (i_en) begin
        col <= col == LAST ? '0 : col + 1'b1;
        row <= col != LAST ? row : row == LAST ? '0 : row + 1'b1;
        if (active && !col[0]) hold <= i_data;
        if (active && col[0] && row[0]) o_data <= quad_max;
      end
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_en && active && col[0] && !row[0]) linebuf[lb_idx] <= pair_max;
  end
endmodule

// File: tb/tb_maxpool_2x2_stream.sv
// tb_maxpool_2x2_stream: checks sizes 4, 5 and 2 against a frame-array reference model plus directed vectors
module tb_maxpool_2x2_stream;
  localparam int DW = 48;
  typedef struct {
    logic en;
    logic signed [DW-1:0] data;
    logic xen;
    logic signed [DW-1:0] xdata;
    logic xdone;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic signed [DW-1:0] data = '0;
  logic oe [3];
  logic ofd [3];
  logic signed [DW-1:0] od [3];
  logic signed [DW-1:0] img [3][25];
  logic signed [DW-1:0] xv [3];
  int k [3];
  int pc [3];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  vec_t tbl [16];
  always #5 clk = ~clk;
  maxpool_2x2_stream #(.IN_SIZE(4), .DATA_WIDTH(DW)) u4 (.i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_data(data),
    .o_en(oe[0]), .o_data(od[0]), .o_frame_done(ofd[0]));
  maxpool_2x2_stream #(.IN_SIZE(5), .DATA_WIDTH(DW)) u5 (.i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_data(data),
    .o_en(oe[1]), .o_data(od[1]), .o_frame_done(ofd[1]));
  maxpool_2x2_stream #(.IN_SIZE(2), .DATA_WIDTH(DW)) u2 (.i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_data(data),
    .o_en(oe[2]), .o_data(od[2]), .o_frame_done(ofd[2]));
  function automatic int sz(input int d);
    return d == 0 ? 4 : d == 1 ? 5 : 2;
  endfunction
  function automatic logic signed [DW-1:0] mx(input logic signed [DW-1:0] a, input logic signed [DW-1:0] b);
    return a > b ? a : b;
  endfunction
  task automatic chk(input string name, input logic signed [DW-1:0] act, input logic signed [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask
  task automatic chk_zero();
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst o_en[%0d]", d), DW'(oe[d]), '0);
      chk($sformatf("rst o_data[%0d]", d), od[d], '0);
      chk($sformatf("rst o_frame_done[%0d]", d), DW'(ofd[d]), '0);
    end
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    en = 1'b0;
    #1;
    chk_zero();
    for (int d = 0; d < 3; d++) begin
      k[d] = 0;
      xv[d] = '0;
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_zero();
    rst_n = 1'b1;
  endtask
  task automatic cycle(input logic e, input logic signed [DW-1:0] dv);
    logic xe [3];
    logic xd [3];
    int s, r, c, a;
    en = e;
    data = dv;
    for (int d = 0; d < 3; d++) begin
      xe[d] = 1'b0;
      xd[d] = 1'b0;
      if (e) begin
        s = sz(d);
        r = k[d] / s;
        c = k[d] % s;
        a = 2 * (s / 2);
        img[d][k[d]] = dv;
        if (r % 2 == 1 && c % 2 == 1 && r < a && c < a) begin
          xe[d] = 1'b1;
          xv[d] = mx(mx(img[d][(r-1)*s+c-1], img[d][(r-1)*s+c]), mx(img[d][r*s+c-1], dv));
          xd[d] = r == a - 1 && c == a - 1;
        end
        k[d] = (k[d] + 1) % (s * s);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int d = 0; d < 3; d++) begin
      if (oe[d]) pc[d]++;
      chk($sformatf("model o_en[%0d]", d), DW'(oe[d]), DW'(xe[d]));
      chk($sformatf("model o_data[%0d]", d), od[d], xv[d]);
      chk($sformatf("model o_frame_done[%0d]", d), DW'(ofd[d]), DW'(xd[d]));
    end
  endtask
  task automatic ramp(input int n);
    for (int i = 1; i <= n; i++) cycle(1'b1, DW'(i));
  endtask
  initial begin
    logic signed [DW-1:0] held;
    held = '0;
    for (int i = 0; i < 16; i++) begin
      tbl[i].en = 1'b1;
      tbl[i].data = DW'(i + 1);
      tbl[i].xen = (i + 1 == 6) || (i + 1 == 8) || (i + 1 == 14) || (i + 1 == 16);
      if (tbl[i].xen) held = DW'(i + 1);
      tbl[i].xdata = held;
      tbl[i].xdone = i + 1 == 16;
    end
    for (int d = 0; d < 3; d++) begin
      k[d] = 0;
      pc[d] = 0;
      xv[d] = '0;
    end
    do_reset();
    for (int i = 0; i < 16; i++) begin
      cycle(tbl[i].en, tbl[i].data);
      chk("tbl o_en", DW'(oe[0]), DW'(tbl[i].xen));
      chk("tbl o_data", od[0], tbl[i].xdata);
      chk("tbl o_frame_done", DW'(ofd[0]), DW'(tbl[i].xdone));
    end
    do_reset();
    pc[1] = 0;
    for (int i = 1; i <= 25; i++) begin
      cycle(1'b1, DW'(i));
      if (i == 19) begin
        chk("odd last o_data", od[1], DW'(19));
        chk("odd last o_frame_done", DW'(ofd[1]), DW'(1));
      end
    end
    chk("odd pulse count", DW'(pc[1]), DW'(4));
    do_reset();
    cycle(1'b1, -DW'(5));
    cycle(1'b1, -DW'(3));
    cycle(1'b1, -DW'(8));
    cycle(1'b1, -DW'(4));
    chk("neg o_en", DW'(oe[2]), DW'(1));
    chk("neg o_data", od[2], -DW'(3));
    chk("neg o_frame_done", DW'(ofd[2]), DW'(1));
    do_reset();
    pc[0] = 0;
    for (int i = 1; i <= 16; i++) begin
      cycle(1'b1, DW'(i));
      repeat (3) cycle(1'b0, DW'($urandom));
    end
    chk("gap pulse count", DW'(pc[0]), DW'(4));
    chk("gap last o_data", od[0], DW'(16));
    do_reset();
    pc[0] = 0;
    ramp(16);
    for (int i = 16; i >= 1; i--) cycle(1'b1, DW'(i));
    chk("b2b pulse count", DW'(pc[0]), DW'(8));
    chk("b2b last o_data", od[0], DW'(6));
    ramp(7);
    do_reset();
    ramp(16);
    chk("post-reset o_data", od[0], DW'(16));
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      cycle($urandom_range(0, 9) < 7, DW'({$urandom, $urandom}));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/maxpool_2x2_stream.md
# maxpool_2x2_stream

Streaming 2x2, stride-2 max-pooling stage. It sits directly downstream of `relu` and consumes its `o_en`/`o_data` stream: one signed 48-bit convolution result per enabled cycle, in raster order, for a square feature map of side `IN_SIZE`. It emits one pooled value per 2x2 window, also in raster order, for the next layer. It holds only a half-row line buffer, never a full frame.

## Interface
Parameters:
- `IN_SIZE`, 4: side of the incoming square map. Must equal `(FM_SIZE-KERNEL_SIZE+2*PADDING)/STRIDE+1` of the upstream PE. Must be ≥ 2.
- `DATA_WIDTH`, 48: sample width, two's complement.
- Derived, not overridable: `OUT_SIZE = IN_SIZE/2`, floor division.

Ports:
- `i_clk`, in, 1: single clock, rising edge.
- `i_rst_n`, in, 1: reset. Asynchronous, active-low.
- `i_en`, in, 1: `i_data` is valid this cycle. Driven by `relu.o_en`.
- `i_data`, in, `DATA_WIDTH`, signed: input sample. Driven by `relu.o_data`.
- `o_en`, out, 1: one-cycle pulse marking a valid pooled result.
- `o_data`, out, `DATA_WIDTH`, signed: pooled result. Holds its value between pulses.
- `o_frame_done`, out, 1: one-cycle pulse, coincident with the last `o_en` of a frame.

## Operation
- **Counters.** `col` and `row` run over 0..`IN_SIZE`-1.
  - They advance only on cycles with `i_en`=1. Idle cycles, i.e. gaps, are ignored with no state change.
  - `col` wraps to 0 and increments `row`.
  - After (`IN_SIZE`-1, `IN_SIZE`-1), both return to 0. The next sample starts a new frame with no idle cycle required.
- **Active region.** A sample is pooled only if `row < 2*OUT_SIZE` and `col < 2*OUT_SIZE`.
  - For odd `IN_SIZE`, the last row and last column are accepted, counted and discarded.
- **Even rows (row[0]=0).**
  - Even col: latch the sample into a hold register.
  - Odd col: write max(hold, sample) into `linebuf[col>>1]`.
  - `linebuf` has `OUT_SIZE` entries of `DATA_WIDTH`.
- **Odd rows (row[0]=1).**
  - Even col: latch the sample into the hold register.
  - Odd col: compute max(hold, sample, `linebuf[col>>1]`), register it into `o_data`, and pulse `o_en`.
- **Frame end.** `o_frame_done` pulses with the output for window (`OUT_SIZE`-1, `OUT_SIZE`-1).
- **Arithmetic.**
  - All comparisons are signed and full-width. Negative values must be handled even though `relu` never produces them.
  - No rounding or saturation; the output is always one of the four inputs.
  - Ties: any equal value, since the result is identical.
- **Output count.** Exactly `OUT_SIZE`² outputs per frame, in window raster order.

## Timing
- **Reset values.** While `i_rst_n`=0:
  - `o_en`=0, `o_data`=0, `o_frame_done`=0.
  - `col`=0, `row`=0, hold register=0.
  - `linebuf` is not reset. Every entry is written before it is read in each frame.
- **Latency.** One cycle. If the bottom-right sample of a window is accepted at rising edge N, `o_en`, `o_data` and `o_frame_done` are valid in the cycle following edge N.
- **Pulse width.** `o_en` and `o_frame_done` are high for exactly one cycle. They deassert at the next edge unless another window completes.
- **Throughput.**
  - One input per cycle, sustained; no backpressure.
  - Maximum output rate is one per 2 input cycles, within odd rows only.
- **Gaps.** Any number of `i_en`=0 cycles may appear between samples, including inside a window. Results are identical to gap-free input; only the timing shifts.
- **Reset mid-frame.** The partial frame is discarded. The first `i_en` sample after deassertion is treated as (0,0). No output is produced for the aborted windows.
- **Back-to-back frames.** The last sample of frame k and the first sample of frame k+1 on consecutive cycles must both be accepted. The frame-k output pulse coincides with the cycle in which frame-k+1 sample (0,0) is presented.

## Test plan
- **Ramp, size 4.** `IN_SIZE`=4; ramp 1..16, contiguous `i_en` -> `o_en` pulses carrying 6, 8, 14, 16. Each pulse is one cycle after samples 6, 8, 14, 16 respectively. `o_frame_done` is set with 16.
- **Odd size.** `IN_SIZE`=5; ramp 1..25 -> outputs 7, 9, 17, 19 only. Row 5 and column 5 produce no outputs. `o_frame_done` is set with 19. Four pulses total.
- **Negative data.** `IN_SIZE`=2; inputs -5, -3, -8, -4 -> single output -3 with `o_frame_done`.
- **Gaps.** `IN_SIZE`=4 ramp 1..16 with `i_en` deasserted for 3 cycles after every sample -> same values 6, 8, 14, 16. No spurious `o_en` during gaps.
- **Back-to-back frames, then reset mid-frame.**
  - Two frames back-to-back (1..16, then 16..1) -> 6, 8, 14, 16, then 16, 14, 8, 6. Second frame: windows (16,15,12,11), (14,13,10,9), (8,7,4,3), (6,5,2,1).
  - Then assert `i_rst_n`=0 after 7 samples of a third frame and release it. All outputs read 0 during reset. A fresh ramp 1..16 yields 6, 8, 14, 16.
